// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: issues one operation to a selected FPU sub-unit, holds its enable until the unit is ready,
// then returns the captured result and flags. Optional macro FPU_SEQ_TIMEOUT_EN builds the busy-wait timeout.
module fpu_op_sequencer #(
    parameter int OPERAND_WIDTH  = 32,
    parameter int NUM_UNITS      = 4,
    parameter int OP_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               fpu_clk,
    input  logic                               fpu_rst_n,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [OP_WIDTH-1:0]                req_op_i,
    input  logic [OPERAND_WIDTH-1:0]           req_a_i,
    input  logic [OPERAND_WIDTH-1:0]           req_b_i,
    output logic [NUM_UNITS-1:0]               unit_en_o,
    output logic [OPERAND_WIDTH-1:0]           unit_a_o,
    output logic [OPERAND_WIDTH-1:0]           unit_b_o,
    input  logic [NUM_UNITS-1:0]               unit_ready_i,
    input  logic [NUM_UNITS*OPERAND_WIDTH-1:0] unit_result_i,
    input  logic [NUM_UNITS-1:0]               unit_overflow_i,
    input  logic [NUM_UNITS-1:0]               unit_zero_i,
    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic [OPERAND_WIDTH-1:0]           rsp_result_o,
    output logic [3:0]                         rsp_flags_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                     r_state;
    logic [OP_WIDTH-1:0]        r_op;
    logic                       r_req_ready;
    logic [NUM_UNITS-1:0]       r_unit_en;
    logic [OPERAND_WIDTH-1:0]   r_unit_a;
    logic [OPERAND_WIDTH-1:0]   r_unit_b;
    logic                       r_rsp_valid;
    logic [OPERAND_WIDTH-1:0]   r_rsp_result;
    logic [3:0]                 r_rsp_flags;

    logic                       w_req_fire;
    logic                       w_req_illegal;
    logic [NUM_UNITS-1:0]       w_req_onehot;
    logic                       w_sel_ready;
    logic                       w_sel_ovf;
    logic                       w_sel_zero;
    logic [OPERAND_WIDTH-1:0]   w_sel_result;
    logic                       w_timeout;

    assign w_req_fire    = req_valid_i & r_req_ready;
    assign w_req_illegal = ({1'b0, req_op_i} >= (OP_WIDTH+1)'(NUM_UNITS));
    assign w_req_onehot  = NUM_UNITS'(1'b1) << req_op_i;

    // Mux out the ready/result/flags of the unit addressed by the latched opcode
    always_comb begin
        w_sel_ready  = 1'b0;
        w_sel_ovf    = 1'b0;
        w_sel_zero   = 1'b0;
        w_sel_result = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_sel_ready  = w_sel_ready | ((r_op == OP_WIDTH'(k)) & unit_ready_i[k]);
            w_sel_ovf    = w_sel_ovf   | ((r_op == OP_WIDTH'(k)) & unit_overflow_i[k]);
            w_sel_zero   = w_sel_zero  | ((r_op == OP_WIDTH'(k)) & unit_zero_i[k]);
            w_sel_result = w_sel_result
                         | ({OPERAND_WIDTH{r_op == OP_WIDTH'(k)}} & unit_result_i[k*OPERAND_WIDTH +: OPERAND_WIDTH]);
        end
    end

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Busy-cycle counter, held at zero outside BUSY so every operation starts counting from 0
    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_timeout            = 1'b0;
`endif

    // Request/response sequencing; every output is a register written here
    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_req_ready  <= 1'b1;
            r_unit_en    <= '0;
            r_unit_a     <= '0;
            r_unit_b     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_fire) begin
                        r_op        <= req_op_i;
                        r_unit_a    <= req_a_i;
                        r_unit_b    <= req_b_i;
                        r_req_ready <= 1'b0;
                        if (w_req_illegal) begin
                            r_state      <= S_RESP;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_result <= '0;
                            r_rsp_flags  <= 4'b1000;
                        end else begin
                            r_state   <= S_BUSY;
                            r_unit_en <= w_req_onehot;
                        end
                    end
                end
                S_BUSY: begin
                    // Ready is tested first so it wins over a coincident timeout
                    if (w_sel_ready) begin
                        r_state      <= S_RESP;
                        r_unit_en    <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= w_sel_result;
                        r_rsp_flags  <= {2'b00, w_sel_ovf, w_sel_zero};
                    end else if (w_timeout) begin
                        r_state      <= S_RESP;
                        r_unit_en    <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= '0;
                        r_rsp_flags  <= 4'b0100;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_unit_en   <= '0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = r_req_ready;
    assign unit_en_o    = r_unit_en;
    assign unit_a_o     = r_unit_a;
    assign unit_b_o     = r_unit_b;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_result_o = r_rsp_result;
    assign rsp_flags_o  = r_rsp_flags;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Randomised bench for fpu_op_sequencer with stub sub-units and a transaction-level reference model.
// Honours FPU_SEQ_TIMEOUT_EN the same way as the design.
module tb_fpu_op_sequencer;
    localparam int W   = 32;
    localparam int N   = 3;
    localparam int OPW = 2;
    localparam int TO  = 8;
`ifdef FPU_SEQ_TIMEOUT_EN
    localparam bit TO_EN  = 1'b1;
    localparam int MAXLAT = 10;
`else
    localparam bit TO_EN  = 1'b0;
    localparam int MAXLAT = 8;
`endif

    logic           fpu_clk = 1'b0;
    logic           fpu_rst_n = 1'b0;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic [OPW-1:0] req_op_i = '0;
    logic [W-1:0]   req_a_i = '0;
    logic [W-1:0]   req_b_i = '0;
    logic [N-1:0]   unit_en_o;
    logic [W-1:0]   unit_a_o;
    logic [W-1:0]   unit_b_o;
    logic [N-1:0]   unit_ready_i = '0;
    logic [N*W-1:0] unit_result_i = '0;
    logic [N-1:0]   unit_overflow_i = '0;
    logic [N-1:0]   unit_zero_i = '0;
    logic           rsp_valid_o;
    logic           rsp_ready_i = 1'b1;
    logic [W-1:0]   rsp_result_o;
    logic [3:0]     rsp_flags_o;

    fpu_op_sequencer #(.OPERAND_WIDTH(W), .NUM_UNITS(N), .OP_WIDTH(OPW), .TIMEOUT_CYCLES(TO)) dut (
        .fpu_clk(fpu_clk), .fpu_rst_n(fpu_rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .unit_en_o(unit_en_o), .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
        .unit_ready_i(unit_ready_i), .unit_result_i(unit_result_i),
        .unit_overflow_i(unit_overflow_i), .unit_zero_i(unit_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o)
    );

    always #5 fpu_clk = ~fpu_clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: phase 0 = waiting for request, 1 = unit working, 2 = response offered
    int         m_ph = 0;
    int         m_wait = 0;
    int         idx;
    logic [1:0] m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0] m_flags = '0;

    always @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            m_ph = 0; m_wait = 0; m_op = '0; m_res = '0; m_flags = '0;
        end else begin
            case (m_ph)
                0: if (req_valid_i) begin
                    m_op = req_op_i; m_a = req_a_i; m_b = req_b_i;
                    if (int'(req_op_i) >= N) begin
                        m_ph = 2; m_res = '0; m_flags = 4'b1000;
                    end else begin
                        m_ph = 1; m_wait = 0;
                    end
                end
                1: begin
                    idx = int'(m_op);
                    if (unit_ready_i[idx]) begin
                        m_ph = 2; m_res = unit_result_i[idx*W +: W];
                        m_flags = {2'b00, unit_overflow_i[idx], unit_zero_i[idx]};
                    end else if (TO_EN && m_wait == TO - 1) begin
                        m_ph = 2; m_res = '0; m_flags = 4'b0100;
                    end else begin
                        m_wait++;
                    end
                end
                2: if (rsp_ready_i) m_ph = 0;
                default: m_ph = 0;
            endcase
        end
    end

    // Per-cycle compare plus enable-spacing bookkeeping
    int low_run = 0, high_run = 0, last_high = 0;
    bit seen_en = 1'b0;
    always @(negedge fpu_clk) begin
        chk("req_ready", req_ready_o, m_ph == 0);
        chk("unit_en", unit_en_o, (m_ph == 1) ? (3'b001 << m_op) : 3'b000);
        chk("rsp_valid", rsp_valid_o, m_ph == 2);
        if (m_ph == 1) begin
            chk("unit_a", unit_a_o, m_a);
            chk("unit_b", unit_b_o, m_b);
        end
        if (m_ph == 2) begin
            chk("rsp_result", rsp_result_o, m_res);
            chk("rsp_flags", rsp_flags_o, m_flags);
        end
        if (unit_en_o != '0) begin
            if (high_run == 0 && seen_en) begin
                n_chk++;
                if (low_run >= 2) n_pass++;
                else $display("FAIL en_low_gap: low cycles %0d, required >= 2", low_run);
            end
            high_run++; low_run = 0; seen_en = 1'b1;
        end else begin
            if (high_run != 0) last_high = high_run;
            high_run = 0; low_run++;
        end
    end

    // Stub sub-units: ready after a per-operation latency (255 = never), noise on idle units
    int      en_age[N];
    int      cur_lat[N];
    int      force_lat = 0;
    bit      fixed_data = 1'b0;
    bit      rsp_rand = 1'b0;
    logic [W-1:0] fres[N];
    logic    fovf[N], fzero[N];
    always @(negedge fpu_clk) begin
        logic [N-1:0]   rdy, ovf, zro;
        logic [N*W-1:0] res;
        for (int k = 0; k < N; k++) begin
            if (unit_en_o[k]) begin
                en_age[k]++;
                if (en_age[k] == 1) cur_lat[k] = (force_lat != 0) ? force_lat : $urandom_range(1, MAXLAT);
                rdy[k] = (cur_lat[k] != 255) && (en_age[k] >= cur_lat[k]);
            end else begin
                en_age[k] = 0;
                rdy[k] = 1'($urandom_range(0, 1));
            end
            res[k*W +: W] = fixed_data ? fres[k] : W'($urandom);
            ovf[k] = fixed_data ? fovf[k] : 1'($urandom_range(0, 1));
            zro[k] = fixed_data ? fzero[k] : 1'($urandom_range(0, 1));
        end
        unit_ready_i = rdy; unit_result_i = res; unit_overflow_i = ovf; unit_zero_i = zro;
        if (rsp_rand) rsp_ready_i = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b;
        while (!req_ready_o && n < 200) begin @(negedge fpu_clk); n++; end
        if (n >= 200) begin
            n_chk++;
            $display("FAIL send_accept: req_ready_o stayed %0b for %0d cycles, required 1", req_ready_o, n);
        end
        @(negedge fpu_clk);
        req_valid_i = 1'b0; req_op_i = 2'($urandom); req_a_i = $urandom; req_b_i = $urandom;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rsp_valid_o && n < 100) begin @(negedge fpu_clk); n++; end
        n_chk++;
        if (rsp_valid_o) n_pass++;
        else $display("FAIL %s: rsp_valid_o=0 after %0d cycles, required 1", name, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            fres[k] = '0; fovf[k] = 1'b0; fzero[k] = 1'b0; en_age[k] = 0; cur_lat[k] = 1;
        end
        repeat (3) @(negedge fpu_clk);
        chk("rst_req_ready", req_ready_o, 1'b1);
        chk("rst_unit_en", unit_en_o, 3'b000);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_unit_a", unit_a_o, 32'h0);
        chk("rst_unit_b", unit_b_o, 32'h0);
        chk("rst_result", rsp_result_o, 32'h0);
        chk("rst_flags", rsp_flags_o, 4'b0000);
        fpu_rst_n = 1'b1;
        @(negedge fpu_clk);

        // Unit 2, ready after 3 enable cycles
        fixed_data = 1'b1; fres[2] = 32'h0000_0003; force_lat = 3;
        send(2'd2, 32'h4040_0000, 32'h3F80_0000);
        chk("t1_en_k1", unit_en_o, 3'b100);
        chk("t1_unit_a", unit_a_o, 32'h4040_0000);
        wait_valid("t1_rsp");
        chk("t1_result", rsp_result_o, 32'h0000_0003);
        chk("t1_flags", rsp_flags_o, 4'b0000);
        chk("t1_en_low", unit_en_o, 3'b000);
        @(negedge fpu_clk);

        // Unit 1 overflow, consumer stalls 5 cycles
        fres[1] = 32'h7FFF_FFFF; fovf[1] = 1'b1; force_lat = 2; rsp_ready_i = 1'b0;
        send(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_valid("t2_rsp");
        repeat (5) begin
            chk("t2_hold_valid", rsp_valid_o, 1'b1);
            chk("t2_hold_result", rsp_result_o, 32'h7FFF_FFFF);
            chk("t2_hold_flags", rsp_flags_o, 4'b0010);
            chk("t2_hold_req_ready", req_ready_o, 1'b0);
            @(negedge fpu_clk);
        end
        rsp_ready_i = 1'b1;
        @(negedge fpu_clk);
        chk("t2_idle_req_ready", req_ready_o, 1'b1);
        chk("t2_idle_valid", rsp_valid_o, 1'b0);

        // Illegal opcode
        send(2'd3, 32'h1, 32'h2);
        chk("ill_en", unit_en_o, 3'b000);
        chk("ill_valid", rsp_valid_o, 1'b1);
        chk("ill_result", rsp_result_o, 32'h0);
        chk("ill_flags", rsp_flags_o, 4'b1000);
        @(negedge fpu_clk);

        // Unit 0 never ready
        force_lat = 255;
        send(2'd0, 32'hAAAA_0000, 32'h5555_0000);
`ifdef FPU_SEQ_TIMEOUT_EN
        wait_valid("to_rsp");
        chk("to_result", rsp_result_o, 32'h0);
        chk("to_flags", rsp_flags_o, 4'b0100);
        @(negedge fpu_clk);
        chk("to_en_high_cycles", last_high, 8);
        send(2'd0, 32'hAAAA_0001, 32'h5555_0001);
        repeat (3) @(negedge fpu_clk);
`else
        begin
            int seen = 0;
            repeat (100) begin @(negedge fpu_clk); if (rsp_valid_o) seen++; end
            chk("no_to_rsp_count", seen, 0);
            chk("no_to_en_held", unit_en_o, 3'b001);
        end
`endif
        // Reset in the middle of BUSY
        #2 fpu_rst_n = 1'b0;
        #1;
        chk("mid_rst_en", unit_en_o, 3'b000);
        chk("mid_rst_valid", rsp_valid_o, 1'b0);
        chk("mid_rst_flags", rsp_flags_o, 4'b0000);
        chk("mid_rst_req_ready", req_ready_o, 1'b1);
        @(negedge fpu_clk);
        @(negedge fpu_clk);
        fpu_rst_n = 1'b1;
        @(negedge fpu_clk);
        fres[1] = 32'hDEAD_BEEF; fovf[1] = 1'b0; fzero[1] = 1'b1; force_lat = 2;
        send(2'd1, 32'h0BAD_F00D, 32'h0000_0001);
        wait_valid("post_rst_rsp");
        chk("post_rst_result", rsp_result_o, 32'hDEAD_BEEF);
        chk("post_rst_flags", rsp_flags_o, 4'b0001);
        @(negedge fpu_clk);

        // Randomised back-to-back traffic
        fixed_data = 1'b0; force_lat = 0; rsp_rand = 1'b1;
        for (int i = 0; i < 250; i++) begin
            send(2'($urandom_range(0, 3)), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge fpu_clk);
        end
        rsp_rand = 1'b0; rsp_ready_i = 1'b1;
        repeat (30) @(negedge fpu_clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
